// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit with HI/LO registers.
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) on
// operand magnitudes, one step per cycle for WIDTH cycles, and sign-fixes the
// result on the final step edge. It also services MTHI/MTLO writes while idle,
// and raises a combinational stall when an instruction needing the unit
// arrives while it is busy.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op       issue MULT(00)/MULTU(01)/DIV(10)/DIVU(11)
//   a, b            rs / rt operands
//   hi_wr, lo_wr    MTHI / MTLO requests, data on wdata
//   mf_req          an MFHI/MFLO sits in EX this cycle
//   hi, lo          HI / LO registers
//   busy            operation in progress
//   stall           freeze PC, IF/ID and ID/EX while busy and the unit is needed
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   ma_q, mb_q;      // |multiplicand| / |divisor|
  logic [2*WIDTH-1:0] acc_q, acc_d;    // MUL: product; DIV: {rem, quot}
  logic               neg_q, rneg_q;   // negate product/quotient; negate remainder
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum, dtmp;
  logic [WIDTH-1:0]   ddiff;
  logic               dge;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               last;

  assign sgn   = ~op[0];
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;

  // Shift-add: add multiplicand to the upper half when the LSB is set,
  // then shift the whole accumulator (carry included) right by one.
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, ma_q & {WIDTH{acc_q[0]}}};
  assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract when it fits. A zero divisor always "fits", giving all-ones
  // quotient and the dividend as remainder.
  assign dtmp    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign dge     = dtmp >= {1'b0, mb_q};
  assign ddiff   = dtmp[WIDTH-1:0] - mb_q;   // exact when dge holds
  assign div_nxt = {(dge ? ddiff : dtmp[WIDTH-1:0]), acc_q[WIDTH-2:0], dge};

  assign acc_d    = (state_q == MUL) ? mul_nxt : div_nxt;
  assign prod_fix = neg_q  ? -mul_nxt : mul_nxt;
  assign q_fix    = neg_q  ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  assign r_fix    = rneg_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
  assign last     = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ma_q    <= abs_a;
            mb_q    <= abs_b;
            neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q  <= sgn & a[WIDTH-1];
            acc_q   <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            cnt_q   <= '0;
            state_q <= op[1] ? DIV : MUL;
          end else begin
            if (hi_wr) hi_q <= wdata;
            if (lo_wr) lo_q <= wdata;
          end
        end
        MUL, DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= IDLE;
            if (state_q == MUL) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | hi_wr | lo_wr | mf_req);
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative MIPS multiply/divide unit in the EX stage, with HI/LO registers.
- Consumes operands and control from the ID/EX pipeline register.
- Executes MULT, MULTU, DIV and DIVU in WIDTH cycles each, and services MTHI, MTLO, MFHI and MFLO.
- Its stall output drives the Wr enables of the PC, IF/ID and ID/EX pipeline registers. While stall is high, the front end freezes.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 4.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue a mult/div operation this cycle.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- hi_wr  in  1  MTHI request.
- lo_wr  in  1  MTLO request.
- wdata  in  WIDTH  MTHI/MTLO data.
- mf_req  in  1  an MFHI/MFLO is in EX this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  an operation is in progress.
- stall  out  1  combinational; freeze the upstream pipeline registers.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, hi=0, lo=0, busy=0, internal counter and accumulators cleared.
  - The in-flight operation is discarded.
- States:
  - IDLE: busy=0. On posedge with start=1:
    - Latch op, a and b.
    - For signed ops, latch magnitudes |a| and |b| and the sign flags.
    - Clear the counter; go to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: one shift-add step per cycle on the magnitudes; 2*WIDTH-bit product accumulator.
  - DIV: one restoring shift-subtract step per cycle on the magnitudes; WIDTH-bit quotient and remainder.
  - MUL/DIV to IDLE: on the WIDTH-th step edge. On that same edge, hi/lo are written and busy falls.
- Latency:
  - busy is high for exactly WIDTH cycles, starting the cycle after the start edge.
  - The new hi/lo values are visible in the cycle after busy falls.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. MULT negates the product iff the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient negated iff the signs differ; remainder takes the dividend's sign (truncating division).
- Divide by zero (not trapped; result is the natural algorithm output):
  - DIVU: lo = all ones, hi = a.
  - DIV: magnitude quotient is all ones, then sign-fixed. a>=0 gives lo = all ones; a<0 gives lo = 1. hi = a in both cases.
- Signed overflow (DIV of most-negative value by -1): lo = 0x80000000, hi = 0 (for WIDTH=32).
- MTHI/MTLO:
  - In IDLE with start=0: hi_wr writes hi <= wdata; lo_wr writes lo <= wdata.
  - hi_wr and lo_wr may both be asserted in the same cycle; both registers take wdata.
  - If start=1 in the same IDLE cycle, start wins and the writes are dropped.
- While busy:
  - start, hi_wr and lo_wr are ignored; the latched operands are unaffected by input changes.
  - The upstream stall keeps the requesting instruction presented until the unit is idle.
- stall = busy & (start | hi_wr | lo_wr | mf_req). It is purely combinational, with no dependence on the registered next state.
  - Independent instructions keep flowing while an operation runs in the background.
  - When busy falls, stall falls in the same cycle; the held instruction then proceeds, and an MF sees the new hi/lo.
- Back-to-back operation:
  - A start held through the stall is accepted on the first IDLE edge.
  - The minimum gap between operations is 0 idle cycles after busy falls.
- hi and lo are registered outputs and change only on the completion edge, an MT write, or reset.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy high for exactly 32 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- During MULT, assert mf_req at busy cycle 5 and hold it -> stall=1 through busy cycle 32, then 0 in the next cycle. hi/lo read in that cycle equal the product. An idle-period mf_req gives stall=0.
- In IDLE: hi_wr=1, wdata=0x12345678 -> hi=0x12345678, lo unchanged. hi_wr with start=1 in the same cycle -> write dropped, operation starts. hi_wr while busy -> ignored and stall=1.
- Start DIV, assert rst at busy cycle 10 -> immediately busy=0, hi=lo=0, stall=0. A new MULT 6*7 afterwards -> lo=42, hi=0.
